// File: rtl/apb_mem_responder.sv
// -----------------------------------------------------------------------------
// apb_mem_responder
//
// APB-style memory target holding DEPTH 32-bit words starting at byte address
// BASE. Each transfer runs through the phases IDLE -> SETUP -> ACCESS -> DONE.
// Up to 15 wait states may be inserted in ACCESS. Byte and halfword accesses
// use right-aligned data and a byte-lane mask. The mask is dsize shifted by
// addr[1:0]. Bad addresses or bad sizes complete with err=1. They do not write,
// and they return odata=0.
//
// Optional feature:
//   APB_MEM_ALIGN_CHECK_EN - when defined, misaligned halfword/word accesses
//                            are rejected with err=1. When undefined, they
//                            proceed and lanes above byte 3 are dropped.
//
// Ports:
//   clk_i    : sole clock, rising edge
//   rts_i    : synchronous active-high reset (storage is not cleared)
//   addr_i   : byte address from the initiator
//   data_i   : right-aligned write data
//   odata_o  : right-aligned, zero-extended read data (held between reads)
//   sel_i    : select, high for the setup and access phases
//   en_i     : enable, high for the access phase
//   wr_i     : 1 = write, 0 = read
//   dsize_i  : size mask, 4'b0001 byte / 4'b0011 halfword / 4'b1111 word
//   ready_o  : registered one-cycle completion pulse
//   err_o    : transfer error, only meaningful while ready_o is high
// -----------------------------------------------------------------------------
module apb_mem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE        = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rts_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] odata_o,
    input  logic        sel_i,
    input  logic        en_i,
    input  logic        wr_i,
    input  logic [3:0]  dsize_i,
    output logic        ready_o,
    output logic        err_o
);

    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] SPAN      = 33'(DEPTH) << 2;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] odata_q, odata_d;
    logic        wr_q, wr_d;
    logic [3:0]  dsize_q, dsize_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH];

    logic [32:0]      offset_s;
    logic             in_range_s;
    logic             size_ok_s;
    logic             misalign_s;
    logic             bad_s;
    logic [3:0]       lanes_s;
    logic [4:0]       shift_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0]      rword_s;
    logic [31:0]      rdata_s;
    logic [31:0]      wdata_s;
    logic             exec_s;
    logic             mem_we_s;

    // Expand a 4-bit byte-lane mask into a 32-bit bit mask.
    function automatic logic [31:0] lane_bits(input logic [3:0] lanes);
        logic [31:0] bits;
        bits = 32'd0;
        for (int i = 0; i < 4; i++) begin
            bits[8*i +: 8] = {8{lanes[i]}};
        end
        return bits;
    endfunction

    // Address/size decode and lane alignment of the latched transfer.
    always_comb begin
        // A 33-bit difference wraps to >= 2^32 when addr < BASE, so one
        // compare covers both ends of the window.
        offset_s   = {1'b0, addr_q} - {1'b0, BASE};
        in_range_s = (offset_s < SPAN);
        size_ok_s  = (dsize_q == 4'b0001) || (dsize_q == 4'b0011) ||
                     (dsize_q == 4'b1111);
`ifdef APB_MEM_ALIGN_CHECK_EN
        misalign_s = ((dsize_q == 4'b0011) && addr_q[0]) ||
                     ((dsize_q == 4'b1111) && (addr_q[1:0] != 2'b00));
`else
        misalign_s = 1'b0;
`endif
        bad_s    = !in_range_s || !size_ok_s || misalign_s;
        // Lanes pushed past byte 3 fall off the 4-bit result.
        lanes_s  = dsize_q << addr_q[1:0];
        shift_s  = {addr_q[1:0], 3'b000};
        idx_s    = offset_s[IDX_W+1:2];
        rword_s  = mem_q[idx_s];
        rdata_s  = (rword_s & lane_bits(lanes_s)) >> shift_s;
        wdata_s  = data_q << shift_s;
        exec_s   = (state_q == ST_ACCESS) && sel_i && en_i && (cnt_q == 4'd0);
        mem_we_s = exec_s && wr_q && !bad_s && !rts_i;
    end

    // Storage: masked byte-lane write. Contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes_s[i]) begin
                    mem_q[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
                end
            end
        end
    end

    // Next-state and next-output logic of the transfer FSM.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        dsize_d = dsize_q;
        cnt_d   = cnt_q;
        odata_d = odata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_i && !en_i) begin
                    addr_d  = addr_i;
                    data_d  = data_i;
                    wr_d    = wr_i;
                    dsize_d = dsize_i;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (!sel_i) begin
                    state_d = ST_IDLE;
                end else if (en_i) begin
                    cnt_d   = WAIT_INIT;
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_ACCESS: begin
                if (!sel_i || !en_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d   = cnt_q - 4'd1;
                end else begin
                    ready_d = 1'b1;
                    err_d   = bad_s;
                    // A good write leaves the last read value in place.
                    if (bad_s) begin
                        odata_d = 32'd0;
                    end else if (wr_q) begin
                        odata_d = odata_q;
                    end else begin
                        odata_d = rdata_s;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rts_i) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            wr_q    <= 1'b0;
            dsize_q <= 4'd0;
            cnt_q   <= 4'd0;
            odata_q <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            dsize_q <= dsize_d;
            cnt_q   <= cnt_d;
            odata_q <= odata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign odata_o = odata_q;
    assign ready_o = ready_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_apb_mem_responder.sv
// -----------------------------------------------------------------------------
// Bench for apb_mem_responder. Instance 0 has no wait states. Instance 1 has
// three wait states. Each transfer pushes its expected result into a
// scoreboard, taken from a byte-level memory model. The result is popped and
// compared when ready is seen.
// -----------------------------------------------------------------------------
module tb_apb_mem_responder;

    localparam int unsigned DEPTH_T = 1024;

    typedef struct {
        logic [31:0] odata;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rts   [2];
    logic [31:0] addr  [2];
    logic [31:0] data  [2];
    logic        sel   [2];
    logic        en    [2];
    logic        wr    [2];
    logic [3:0]  dsize [2];

    logic [31:0] odata0, odata1;
    logic        rdy0, rdy1, err0, err1;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb [$];
    logic [7:0]  mdl [bit [32:0]];
    logic [31:0] last_od [2];
    logic        seen_a;

    apb_mem_responder #(.DEPTH(DEPTH_T), .BASE(32'h0000_0000), .WAIT_CYCLES(0)) u_dut0 (
        .clk_i(clk), .rts_i(rts[0]), .addr_i(addr[0]), .data_i(data[0]),
        .odata_o(odata0), .sel_i(sel[0]), .en_i(en[0]), .wr_i(wr[0]),
        .dsize_i(dsize[0]), .ready_o(rdy0), .err_o(err0)
    );

    apb_mem_responder #(.DEPTH(DEPTH_T), .BASE(32'h0000_0000), .WAIT_CYCLES(3)) u_dut1 (
        .clk_i(clk), .rts_i(rts[1]), .addr_i(addr[1]), .data_i(data[1]),
        .odata_o(odata1), .sel_i(sel[1]), .en_i(en[1]), .wr_i(wr[1]),
        .dsize_i(dsize[1]), .ready_o(rdy1), .err_o(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic rdy_of(input int idx);
        return (idx == 0) ? rdy0 : rdy1;
    endfunction

    function automatic logic err_of(input int idx);
        return (idx == 0) ? err0 : err1;
    endfunction

    function automatic logic [31:0] od_of(input int idx);
        return (idx == 0) ? odata0 : odata1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte-level reference: one entry per byte address, per instance.
    task automatic model(input int idx, input logic [31:0] a, input logic [31:0] d,
                         input logic w, input logic [3:0] ds, output exp_t e);
        int        n;
        logic      bad;
        bit [32:0] key;
        case (ds)
            4'b0001: n = 1;
            4'b0011: n = 2;
            4'b1111: n = 4;
            default: n = 0;
        endcase
        bad = (n == 0) || (a >= 32'(4 * DEPTH_T));
`ifdef APB_MEM_ALIGN_CHECK_EN
        if ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00)) bad = 1'b1;
`endif
        e.err   = bad;
        e.lat   = (idx == 0) ? 1 : 4;
        e.odata = 32'd0;
        if (!bad) begin
            for (int k = 0; k < n; k++) begin
                if (int'(a[1:0]) + k < 4) begin
                    key = {idx[0], a + 32'(k)};
                    if (w) mdl[key] = d[8*k +: 8];
                    else   e.odata[8*k +: 8] = mdl[key];
                end
            end
            if (w) e.odata = last_od[idx];
        end
        last_od[idx] = e.odata;
    endtask

    task automatic xfer(input int idx, input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic [3:0] ds, input string tag);
        exp_t e;
        exp_t got;
        int   edges;
        logic seen;
        model(idx, a, d, w, ds, e);
        sb.push_back(e);
        @(negedge clk);
        sel[idx] = 1'b1; en[idx] = 1'b0; addr[idx] = a;
        data[idx] = d; wr[idx] = w; dsize[idx] = ds;
        @(negedge clk);
        en[idx] = 1'b1;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (rdy_of(idx) === 1'b1) seen = 1'b1;
        end
        sel[idx] = 1'b0; en[idx] = 1'b0;
        got = sb.pop_front();
        chk({tag, "_ready"}, 32'(seen), 32'd1);
        chk({tag, "_lat"}, 32'(edges - 1), 32'(got.lat));
        chk({tag, "_odata"}, od_of(idx), got.odata);
        chk({tag, "_err"}, 32'(err_of(idx)), 32'(got.err));
        @(posedge clk); #1;
        chk({tag, "_ready_drop"}, 32'(rdy_of(idx)), 32'd0);
        chk({tag, "_err_drop"}, 32'(err_of(idx)), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rts[i] = 1'b1; addr[i] = 32'd0; data[i] = 32'd0; sel[i] = 1'b0;
            en[i] = 1'b0; wr[i] = 1'b0; dsize[i] = 4'd0; last_od[i] = 32'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rts[0] = 1'b0; rts[1] = 1'b0;
        chk("rst_ready0", 32'(rdy0), 32'd0);
        chk("rst_err0",   32'(err0), 32'd0);
        chk("rst_odata0", odata0,    32'd0);
        chk("rst_ready1", 32'(rdy1), 32'd0);
        chk("rst_err1",   32'(err1), 32'd0);
        chk("rst_odata1", odata1,    32'd0);

        // Zero wait states: word write then read back.
        xfer(0, 32'h10, 32'hDEAD_BEEF, 1'b1, 4'b1111, "w_word");
        xfer(0, 32'h10, 32'h0,         1'b0, 4'b1111, "r_word");
        // Byte merge and sub-word reads.
        xfer(0, 32'h10, 32'h1122_3344, 1'b1, 4'b1111, "w_base");
        xfer(0, 32'h13, 32'h0000_00A5, 1'b1, 4'b0001, "w_byte");
        xfer(0, 32'h10, 32'h0,         1'b0, 4'b1111, "r_merge");
        xfer(0, 32'h12, 32'h0,         1'b0, 4'b0011, "r_half");
        xfer(0, 32'h11, 32'h0,         1'b0, 4'b0001, "r_byte");
        // Out-of-range write must not alias onto word 0.
        xfer(0, 32'h0,    32'h55AA_55AA, 1'b1, 4'b1111, "w_word0");
        xfer(0, 32'h1000, 32'h1234_5678, 1'b1, 4'b1111, "w_oor");
        xfer(0, 32'h0,    32'h0,         1'b0, 4'b1111, "r_word0");
        // Illegal size.
        xfer(0, 32'h10, 32'hFFFF_FFFF, 1'b1, 4'b0111, "w_badsize");
        xfer(0, 32'h10, 32'h0,         1'b0, 4'b1111, "r_after_bad");
        // Misaligned accesses (outcome depends on the alignment option).
        xfer(0, 32'h12, 32'h0,         1'b0, 4'b1111, "r_misal");
        xfer(0, 32'h13, 32'h0000_BEEF, 1'b1, 4'b0011, "w_misal");
        xfer(0, 32'h13, 32'h0,         1'b0, 4'b0001, "r_b3");

        // Three wait states.
        xfer(1, 32'h20, 32'hCAFE_F00D, 1'b1, 4'b1111, "w3_word");
        xfer(1, 32'h20, 32'h0,         1'b0, 4'b1111, "r3_word");

        // Reset on the edge that would complete a write.
        @(negedge clk);
        sel[1] = 1'b1; en[1] = 1'b0; addr[1] = 32'h20;
        data[1] = 32'h0BAD_BAD0; wr[1] = 1'b1; dsize[1] = 4'b1111;
        @(negedge clk);
        en[1] = 1'b1;
        seen_a = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rdy1 === 1'b1) seen_a = 1'b1;
        end
        @(negedge clk);
        rts[1] = 1'b1;
        @(posedge clk); #1;
        if (rdy1 === 1'b1) seen_a = 1'b1;
        chk("abort_odata", odata1,    32'd0);
        chk("abort_err",   32'(err1), 32'd0);
        @(negedge clk);
        rts[1] = 1'b0; sel[1] = 1'b0; en[1] = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rdy1 === 1'b1) seen_a = 1'b1;
        end
        chk("abort_no_ready", 32'(seen_a), 32'd0);
        last_od[1] = 32'd0;
        xfer(1, 32'h20, 32'h0, 1'b0, 4'b1111, "r3_after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
